// File: rtl/hex_scan_pkg.sv
// Shared constants and helpers for the multiplexed hex display scanners.
package hex_scan_pkg;

  localparam int unsigned DIGITS_DEFAULT = 4;
  localparam int unsigned DIV_DEFAULT    = 50000;
  localparam int unsigned DIV_SIM        = 4;
  localparam int unsigned MAX_DIGITS     = 8;

  // Active-low one-cold digit enable; callers cast down to their digit count.
  function automatic logic [MAX_DIGITS-1:0] one_cold(input int unsigned idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running prescaler: tick is high for one cycle out of every DIV.
module scan_prescaler
  import hex_scan_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Count 0..DIV-1 and restart on tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex display driver with frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_BLANK_EN.
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEFAULT,
  parameter int unsigned DIV    = DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  blank,
  output logic                  frame
);

  localparam int unsigned IW = $clog2(DIGITS);

  logic                tick;
  logic                wrap;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] hold;
  logic [4*DIGITS-1:0] disp;
  logic                pend;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign wrap = tick && (idx == IW'(DIGITS - 1));

  // Digit index advances on each tick and wraps explicitly at DIGITS-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     idx <= '0;
    else if (wrap) idx <= '0;
    else if (tick) idx <= idx + IW'(1);
  end

  // Capture on load; promote to the display only on wrap, a coincident load bypassing hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold  <= '0;
      disp  <= '0;
      pend  <= 1'b0;
      frame <= 1'b0;
    end else begin
      frame <= wrap;
      if (load) hold <= value;
      if (wrap) begin
        pend <= 1'b0;
        if (load)      disp <= value;
        else if (pend) disp <= hold;
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  assign nibble   = disp[{idx, 2'b00} +: 4];
  assign digit_en = DIGITS'(one_cold(32'(idx)));

`ifdef HEX_SCAN_BLANK_EN
  logic upper_zero;

  // Blank a non-zero digit position when it and every higher digit are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((i >= 32'(idx)) && (disp[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    blank = (idx != '0) && upper_zero;
  end
`else
  assign blank = 1'b0;
`endif

endmodule
